// File: rtl/psum_bank_accum.sv
// psum_bank_accum: COL-lane partial-sum bank (write / read / accumulate / whole-bank clear).
// Build option PSUM_SAT_EN: saturating accumulate with one extra output stage (READ latency 3).
//   state    | meaning
//   ST_IDLE  | accepting requests, pipeline may be busy
//   ST_DRAIN | CLEAR accepted, waiting for earlier ops to retire
//   ST_CLEAR | zeroing one address per cycle, 0..DEPTH-1
module psum_bank_accum #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 32,
    parameter int DEPTH   = 2048,
    parameter int AW      = 11
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [AW-1:0]          req_addr,
    input  logic [COL*PSUM_BW-1:0] req_data,
    input  logic [COL-1:0]         req_mask,
    output logic                   rd_valid,
    output logic [COL*PSUM_BW-1:0] rd_data,
    output logic                   busy
);
    localparam int W = COL * PSUM_BW;
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ACC   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_clr_addr;
    logic            w_accept;
    logic            w_pipe_empty;

    logic [W-1:0]    r_mem [DEPTH];
    logic [W-1:0]    r_rd_q;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_wa;
    logic [W-1:0]    w_mem_wd;

    logic            r_s1_valid;
    logic [1:0]      r_s1_op;
    logic [AW-1:0]   r_s1_addr;
    logic [W-1:0]    r_s1_data;
    logic [COL-1:0]  r_s1_mask;

    logic            r_s2_valid;
    logic [1:0]      r_s2_op;
    logic [AW-1:0]   r_s2_addr;
    logic [W-1:0]    r_s2_data;
    logic [COL-1:0]  r_s2_mask;
    logic            r_s2_fwd;
    logic [W-1:0]    r_s2_fwd_data;
    logic [W-1:0]    w_s2_old;
    logic [W-1:0]    w_s2_new;
    logic            w_s2_wr;

    logic [PSUM_BW-1:0] w_col_a [COL];
    logic [PSUM_BW-1:0] w_col_b [COL];
    logic [PSUM_BW-1:0] w_col_s [COL];

    logic            w_fwd_hit;
    logic [W-1:0]    w_fwd_data;
    logic            w_wb_en;
    logic [AW-1:0]   w_wb_addr;
    logic [W-1:0]    w_wb_data;
    logic            w_out_valid;
    logic [W-1:0]    w_out_data;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign busy      = (r_state != ST_IDLE) | ~w_pipe_empty;
    assign rd_valid  = w_out_valid;
    assign rd_data   = w_out_valid ? w_out_data : '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && req_op == OP_CLEAR) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pipe_empty) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Storage is deliberately not reset; the pipeline is idle during a sweep.
    assign w_mem_we = (r_state == ST_CLEAR) | w_wb_en;
    assign w_mem_wa = (r_state == ST_CLEAR) ? r_clr_addr : w_wb_addr;
    assign w_mem_wd = (r_state == ST_CLEAR) ? '0 : w_wb_data;

    always_ff @(posedge CLK) begin
        if (w_mem_we)
            r_mem[w_mem_wa] <= w_mem_wd;
        r_rd_q <= r_mem[r_s1_addr];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_fwd   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept && (req_op != OP_CLEAR);
            r_s2_valid <= r_s1_valid;
            r_s2_fwd   <= w_fwd_hit;
        end
    end

    always_ff @(posedge CLK) begin
        r_s1_op       <= req_op;
        r_s1_addr     <= req_addr;
        r_s1_data     <= req_data;
        r_s1_mask     <= req_mask;
        r_s2_op       <= r_s1_op;
        r_s2_addr     <= r_s1_addr;
        r_s2_data     <= r_s1_data;
        r_s2_mask     <= r_s1_mask;
        r_s2_fwd_data <= w_fwd_data;
    end

    // A younger op reading an address still being written sees the pending value.
    assign w_s2_old = r_s2_fwd ? r_s2_fwd_data : r_rd_q;
    assign w_s2_wr  = r_s2_valid && (r_s2_op != OP_READ);

    always_comb begin
        w_s2_new = w_s2_old;
        for (int c = 0; c < COL; c++) begin
            w_col_a[c] = w_s2_old[c*PSUM_BW +: PSUM_BW];
            w_col_b[c] = r_s2_data[c*PSUM_BW +: PSUM_BW];
            w_col_s[c] = w_col_a[c] + w_col_b[c];
`ifdef PSUM_SAT_EN
            if ((w_col_a[c][PSUM_BW-1] == w_col_b[c][PSUM_BW-1]) &&
                (w_col_s[c][PSUM_BW-1] != w_col_a[c][PSUM_BW-1]))
                w_col_s[c] = w_col_a[c][PSUM_BW-1] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                                   : {1'b0, {(PSUM_BW-1){1'b1}}};
`endif
            if (r_s2_mask[c]) begin
                if (r_s2_op == OP_WRITE)
                    w_s2_new[c*PSUM_BW +: PSUM_BW] = w_col_b[c];
                else if (r_s2_op == OP_ACC)
                    w_s2_new[c*PSUM_BW +: PSUM_BW] = w_col_s[c];
            end
        end
    end

`ifdef PSUM_SAT_EN
    logic            r_s3_valid;
    logic [1:0]      r_s3_op;
    logic [AW-1:0]   r_s3_addr;
    logic [W-1:0]    r_s3_data;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_s3_valid <= 1'b0;
        else
            r_s3_valid <= r_s2_valid;
    end

    always_ff @(posedge CLK) begin
        r_s3_op   <= r_s2_op;
        r_s3_addr <= r_s2_addr;
        r_s3_data <= w_s2_new;
    end

    // S2 is younger than S3, so it wins when both match.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = w_s2_new;
        if (w_s2_wr && r_s2_addr == r_s1_addr) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = w_s2_new;
        end else if (r_s3_valid && r_s3_op != OP_READ && r_s3_addr == r_s1_addr) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_s3_data;
        end
    end

    assign w_wb_en      = r_s3_valid && (r_s3_op != OP_READ);
    assign w_wb_addr    = r_s3_addr;
    assign w_wb_data    = r_s3_data;
    assign w_out_valid  = r_s3_valid && (r_s3_op == OP_READ);
    assign w_out_data   = r_s3_data;
    assign w_pipe_empty = ~r_s1_valid & ~r_s2_valid & ~r_s3_valid;
`else
    assign w_fwd_hit    = w_s2_wr && (r_s2_addr == r_s1_addr);
    assign w_fwd_data   = w_s2_new;
    assign w_wb_en      = w_s2_wr;
    assign w_wb_addr    = r_s2_addr;
    assign w_wb_data    = w_s2_new;
    assign w_out_valid  = r_s2_valid && (r_s2_op == OP_READ);
    assign w_out_data   = w_s2_new;
    assign w_pipe_empty = ~r_s1_valid & ~r_s2_valid;
`endif

    a_addr_range: assert property (@(posedge CLK) disable iff (!RESET_N)
        (w_accept && req_op != OP_CLEAR) |-> ({1'b0, req_addr} < (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_psum_bank_accum.sv
// Bench for psum_bank_accum: directed corner cases plus random traffic against a sequential model.
module tb_psum_bank_accum;
    localparam int COL = 8, PSUM_BW = 32, DEPTH = 2048, AW = 11;
    localparam int W = COL * PSUM_BW;
`ifdef PSUM_SAT_EN
    localparam int LAT = 3;
    localparam bit SAT = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit SAT = 1'b0;
`endif
    localparam logic [1:0] OP_CLEAR = 2'b00, OP_WRITE = 2'b01, OP_ACC = 2'b10, OP_READ = 2'b11;
    localparam longint MAXV = (longint'(1) << (PSUM_BW-1)) - 1;
    localparam longint MINV = -(longint'(1) << (PSUM_BW-1));

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = '0;
    logic [AW-1:0]  req_addr = '0;
    logic [W-1:0]   req_data = '0;
    logic [COL-1:0] req_mask = '0;
    logic           rd_valid;
    logic [W-1:0]   rd_data;
    logic           busy;

    psum_bank_accum #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: storage as a plain array, ops applied in acceptance order.
    logic [W-1:0] mdl [DEPTH];
    typedef struct { int cyc; logic [W-1:0] data; } exp_t;
    exp_t expq[$];
    bit mon_en = 1'b0;

    function automatic logic [W-1:0] rep(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    function automatic logic [PSUM_BW-1:0] add_col(input logic [PSUM_BW-1:0] a, input logic [PSUM_BW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (SAT) begin
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
        end
        return s[PSUM_BW-1:0];
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [W-1:0] data, input logic [COL-1:0] mask);
        exp_t e;
        for (int c = 0; c < COL; c++) begin
            if (mask[c] && op == OP_WRITE)
                mdl[addr][c*PSUM_BW +: PSUM_BW] = data[c*PSUM_BW +: PSUM_BW];
            else if (mask[c] && op == OP_ACC)
                mdl[addr][c*PSUM_BW +: PSUM_BW] = add_col(mdl[addr][c*PSUM_BW +: PSUM_BW],
                                                          data[c*PSUM_BW +: PSUM_BW]);
        end
        if (op == OP_READ) begin
            e.cyc  = cyc + LAT;
            e.data = mdl[addr];
            expq.push_back(e);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [W-1:0] data, input logic [COL-1:0] mask);
        int waited = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; req_mask = mask;
        while (!req_ready && waited < 5000) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!req_ready) chk("req_timeout", W'(0), W'(1));
        else model_apply(op, addr, data, mask);
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_clear();
        issue(OP_CLEAR, '0, '0, '0);
        for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (mon_en && rd_valid) begin
            if (expq.size() == 0) chk("rd_spurious", W'(1), W'(0));
            else begin
                e = expq.pop_front();
                chk("rd_cycle", W'(cyc), W'(e.cyc));
                chk("rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int low;
        logic [W-1:0] d;
        logic [1:0] op;
        #23 RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Reset mid-stream while a READ result is on the output.
        issue(OP_WRITE, 11'd1, rep(32'h5), '1);
        issue(OP_READ, 11'd1, '0, '1);
        repeat (LAT - 1) @(posedge CLK);
        #2;
        chk("pre_rst_rd_valid", W'(rd_valid), W'(1));
        RESET_N = 1'b0;
        #1;
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_rd_data", rd_data, W'(0));
        chk("rst_req_ready", W'(req_ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK); #1;
        expq.delete();
        mon_en = 1'b1;

        do_clear();
        issue(OP_WRITE, 11'd5, rep(32'h10), '1);
        issue(OP_READ, 11'd5, '0, '1);

        issue(OP_WRITE, 11'd7, '0, '1);
        issue(OP_ACC, 11'd7, rep(32'd3), '1);
        issue(OP_ACC, 11'd7, rep(32'd4), '1);
        issue(OP_ACC, 11'd7, rep(32'd5), '1);
        issue(OP_READ, 11'd7, '0, '1);

        issue(OP_WRITE, 11'd9, rep(32'h55), '1);
        issue(OP_WRITE, 11'd9, rep(32'hAA), 8'b0000_0101);
        issue(OP_READ, 11'd9, '0, '1);

        issue(OP_WRITE, 11'd11, rep(32'h7FFF_FFFF), '1);
        issue(OP_ACC, 11'd11, rep(32'd1), '1);
        issue(OP_READ, 11'd11, '0, '1);
        issue(OP_WRITE, 11'd12, rep(32'h8000_0000), '1);
        issue(OP_ACC, 11'd12, rep(32'hFFFF_FFFF), 8'hF0);
        issue(OP_READ, 11'd12, '0, '1);

        // CLEAR right behind a pending ACC.
        issue(OP_ACC, 11'd7, rep(32'd1), '1);
        issue(OP_CLEAR, '0, '0, '0);
        for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
        chk("clr_busy", W'(busy), W'(1));
        low = 0;
        while (!req_ready && low < 5000) begin
            low++;
            @(posedge CLK); #1;
        end
        chk("clr_ready_low_min", W'(low > DEPTH), W'(1));
        chk("clr_ready_low_max", W'(low <= DEPTH + LAT + 1), W'(1));
        repeat (LAT + 1) @(posedge CLK);
        #1;
        chk("clr_idle_busy", W'(busy), W'(0));
        issue(OP_READ, 11'd7, '0, '1);
        issue(OP_READ, 11'(DEPTH - 1), '0, '1);

        // Reset partway through a sweep.
        for (int a = 0; a < 4; a++) issue(OP_WRITE, 11'(a), rep(32'h11 + 32'(a)), '1);
        issue(OP_WRITE, 11'd1000, rep(32'h33), '1);
        issue(OP_WRITE, 11'(DEPTH - 1), rep(32'h77), '1);
        issue(OP_WRITE, 11'(DEPTH - 2), rep(32'h78), '1);
        repeat (LAT + 2) @(posedge CLK);
        #1;
        issue(OP_CLEAR, '0, '0, '0);
        repeat (100) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #3 RESET_N = 1'b1;
        @(posedge CLK); #1;
        for (int a = 0; a < 64; a++) mdl[a] = '0;
        issue(OP_READ, 11'd0, '0, '1);
        issue(OP_READ, 11'd3, '0, '1);
        issue(OP_READ, 11'd1000, '0, '1);
        issue(OP_READ, 11'(DEPTH - 1), '0, '1);
        issue(OP_READ, 11'(DEPTH - 2), '0, '1);

        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < COL; c++) d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom());
            op = 2'($urandom_range(1, 3));
            issue(op, 11'($urandom_range(0, 7)), d, COL'($urandom()));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end

        repeat (LAT + 3) @(posedge CLK);
        #1;
        chk("exp_queue_drained", W'(expq.size()), W'(0));
        chk("end_busy", W'(busy), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
